// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, imem handshake, issue hold, next-PC select, sticky fault
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_pc_sel, i_alu_data  next-PC select and branch/jump target, sampled on the ack edge
//   i_instr_ack           core has committed the presented instruction
//   o_imem_req/o_imem_addr, i_imem_rvalid/i_imem_rdata  instruction memory request/response
//   o_instr_data/o_instr_valid, o_pc, o_pc_four         presented instruction and its PC
//   o_fault, o_fault_cause                              sticky fault flag and first cause
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data,
    input  logic        i_instr_ack,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_data,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_FAULT} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_valid;
    logic        r_fault;
    logic [1:0]  r_cause;

    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    // Bit 0 is always dropped (JALR semantics applied to every target);
    // bit 1 survives so a half-word-aligned target can be trapped.
    assign w_target  = i_alu_data & ~32'h0000_0001;
    assign w_next_pc = i_pc_sel ? w_target : r_pc + 32'd4;

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_pc_four     = r_pc + 32'd4;
    assign o_instr_data  = r_instr;
    assign o_instr_valid = r_valid;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_cnt   <= 8'd0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_cnt   <= 8'd0;
                end
                S_REQ: begin
                    if (i_imem_rvalid) begin
                        r_cnt <= 8'd0;
                        r_req <= 1'b0;
                        if (i_imem_rdata[1:0] == 2'b11) begin
                            r_instr <= i_imem_rdata;
                            r_valid <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_fault <= 1'b1;
                            r_cause <= 2'b11;
                            r_state <= S_FAULT;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        // The TIMEOUT-th request cycle just ended without a response.
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_cause <= 2'b10;
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (i_instr_ack) begin
                        r_valid <= 1'b0;
                        r_instr <= 32'd0;
                        if (w_next_pc[1:0] != 2'b00) begin
                            r_fault <= 1'b1;
                            r_cause <= 2'b01;
                            r_state <= S_FAULT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

endmodule
